// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: control inputs, memory address/data path and the downstream
// valid/ready instruction handshake. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  run_i;
  logic                  jump_en_i;
  logic [DATA_WIDTH-1:0] jump_addr_i;
  logic                  Instr_ready_i;
  logic [DATA_WIDTH-1:0] Mem_Instr_i;
  logic [DATA_WIDTH-1:0] Mem_Address_o;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic                  Instr_valid_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic                  Fetch_busy_o;

  modport master (
    input  run_i, jump_en_i, jump_addr_i, Instr_ready_i, Mem_Instr_i,
    output Mem_Address_o, Instr_o, Instr_valid_o, PC_o, Fetch_busy_o
  );

  modport slave (
    output run_i, jump_en_i, jump_addr_i, Instr_ready_i, Mem_Instr_i,
    input  Mem_Address_o, Instr_o, Instr_valid_o, PC_o, Fetch_busy_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC owner, absorbs one-cycle memory read latency, holds the word
// until downstream accepts it. Optional handshake counter behind `FETCH_COUNT_EN.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]           Fetch_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  localparam logic [DATA_WIDTH-1:0] LAST_PC = TEXT_BASE + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr;
  logic                  valid;
  logic                  busy;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] jump_pc;
  logic                  jaddr_unused;

  assign next_pc      = (pc == LAST_PC) ? TEXT_BASE : pc + DATA_WIDTH'(4);
  assign jump_pc      = {bus.jump_addr_i[DATA_WIDTH-1:2], 2'b00};
  assign jaddr_unused = ^bus.jump_addr_i[1:0];

  assign bus.Mem_Address_o = pc;
  assign bus.PC_o          = pc;
  assign bus.Instr_o       = instr;
  assign bus.Instr_valid_o = valid;
  assign bus.Fetch_busy_o  = busy;

  // Jump outranks everything, including a same-cycle handshake in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= TEXT_BASE;
      instr <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else if (bus.jump_en_i) begin
      pc    <= jump_pc;
      valid <= 1'b0;
      if (state != IDLE) begin
        state <= ISSUE;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: if (bus.run_i) begin
          state <= ISSUE;
          busy  <= 1'b1;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          instr <= bus.Mem_Instr_i;
          valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (bus.Instr_ready_i) begin
          valid <= 1'b0;
          pc    <= next_pc;
          state <= bus.run_i ? ISSUE : IDLE;
          busy  <= bus.run_i;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      Fetch_count_o <= '0;
    else if (state == HOLD && bus.Instr_ready_i && !bus.jump_en_i)
      Fetch_count_o <= Fetch_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences and a randomized
// run against a transaction-level PC model. Memory returns tag(address) one cycle late.
module tb_instr_fetch_unit;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  instr_fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FETCH_COUNT_EN
  logic [31:0] fcount;
`endif

  instr_fetch_unit #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .TEXT_BASE(BASE)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef FETCH_COUNT_EN
    ,
    .Fetch_count_o (fcount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a == BASE + 32'(4 * (DEPTH - 1))) ? BASE : a + 32'd4;
  endfunction

  // synchronous-read memory: word for the address sampled at the previous edge
  always @(posedge clk) bus.Mem_Instr_i <= tag(bus.Mem_Address_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.Instr_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_valid: got no valid expected valid within 20 cycles");
    end
  endtask

  task automatic drive_idle();
    bus.run_i         = 1'b0;
    bus.jump_en_i     = 1'b0;
    bus.jump_addr_i   = '0;
    bus.Instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.PC_o, BASE);
    chk("rst_addr", bus.Mem_Address_o, BASE);
    chk("rst_instr", bus.Instr_o, 32'h0);
    chk("rst_valid", 32'(bus.Instr_valid_o), 32'h0);
    chk("rst_busy", 32'(bus.Fetch_busy_o), 32'h0);
`ifdef FETCH_COUNT_EN
    chk("rst_count", fcount, 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        run, jump, ready;
    logic [31:0] jaddr;
    logic        ev, eb;
    logic [31:0] epc, einstr;
  } vec_t;

  function automatic vec_t mk(input logic run, input logic jump, input logic ready,
                              input logic [31:0] jaddr, input logic ev, input logic eb,
                              input logic [31:0] epc, input logic [31:0] einstr);
    vec_t v;
    v.run = run; v.jump = jump; v.ready = ready; v.jaddr = jaddr;
    v.ev = ev; v.eb = eb; v.epc = epc; v.einstr = einstr;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[22];
    logic [31:0] t0, t4, t20, t40, mpc;
    bit          ok, vnow, jmp;
    int          hs;

    t0  = tag(BASE);
    t4  = tag(BASE + 32'h4);
    t20 = tag(BASE + 32'h20);
    t40 = tag(BASE + 32'h40);
    //           run jmp rdy jaddr         v  b  pc                 instr
    vt[0]  = mk(1, 0, 1, 32'h0,          0, 1, BASE,              32'h0);
    vt[1]  = mk(1, 0, 1, 32'h0,          0, 1, BASE,              32'h0);
    vt[2]  = mk(1, 0, 0, 32'h0,          1, 1, BASE,              t0);
    vt[3]  = mk(1, 0, 1, 32'h0,          0, 1, BASE + 32'h4,      t0);
    vt[4]  = mk(1, 0, 0, 32'h0,          0, 1, BASE + 32'h4,      t0);
    vt[5]  = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h4,      t4);
    vt[6]  = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h4,      t4);
    vt[7]  = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h4,      t4);
    vt[8]  = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h4,      t4);
    vt[9]  = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h4,      t4);
    vt[10] = mk(1, 0, 1, 32'h0,          0, 1, BASE + 32'h8,      t4);
    vt[11] = mk(1, 0, 0, 32'h0,          0, 1, BASE + 32'h8,      t4);
    vt[12] = mk(1, 1, 0, 32'h0040_0023, 0, 1, BASE + 32'h20,     t4);
    vt[13] = mk(1, 0, 0, 32'h0,          0, 1, BASE + 32'h20,     t4);
    vt[14] = mk(1, 0, 0, 32'h0,          1, 1, BASE + 32'h20,     t20);
    vt[15] = mk(1, 1, 1, 32'h0040_0041, 0, 1, BASE + 32'h40,     t20);
    vt[16] = mk(0, 0, 0, 32'h0,          0, 1, BASE + 32'h40,     t20);
    vt[17] = mk(0, 0, 0, 32'h0,          1, 1, BASE + 32'h40,     t40);
    vt[18] = mk(0, 0, 1, 32'h0,          0, 0, BASE + 32'h44,     t40);
    vt[19] = mk(0, 1, 0, 32'h1234_5677, 0, 0, 32'h1234_5674,     t40);
    vt[20] = mk(1, 1, 0, 32'h0040_0010, 0, 0, BASE + 32'h10,     t40);
    vt[21] = mk(1, 0, 0, 32'h0,          0, 1, BASE + 32'h10,     t40);

    // ---- table-driven cycle vectors
    do_reset();
    for (int i = 0; i < 22; i++) begin
      bus.run_i         = vt[i].run;
      bus.jump_en_i     = vt[i].jump;
      bus.jump_addr_i   = vt[i].jaddr;
      bus.Instr_ready_i = vt[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus.Instr_valid_o), 32'(vt[i].ev));
      chk($sformatf("vec%0d_busy", i), 32'(bus.Fetch_busy_o), 32'(vt[i].eb));
      chk($sformatf("vec%0d_pc", i), bus.PC_o, vt[i].epc);
      chk($sformatf("vec%0d_addr", i), bus.Mem_Address_o, vt[i].epc);
      chk($sformatf("vec%0d_instr", i), bus.Instr_o, vt[i].einstr);
    end
`ifdef FETCH_COUNT_EN
    chk("vec_count", fcount, 32'd3);
`endif

    // ---- throughput: one-cycle valid pulses every 3 cycles
    do_reset();
    bus.run_i = 1'b1;
    bus.Instr_ready_i = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("rate%0d_valid", j), 32'(bus.Instr_valid_o), 32'((j % 3) == 2));
      if ((j % 3) == 2)
        chk($sformatf("rate%0d_instr", j), bus.Instr_o, tag(BASE + 32'(4 * (j / 3))));
    end

    // ---- wrap at the last text word
    do_reset();
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = BASE + 32'hF8;
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    chk("wrap_jump_pc", bus.PC_o, BASE + 32'hF8);
    chk("wrap_jump_busy", 32'(bus.Fetch_busy_o), 32'h0);
    bus.run_i = 1'b1;
    bus.Instr_ready_i = 1'b1;
    wait_valid(ok);
    chk("wrap_instr_f8", bus.Instr_o, tag(BASE + 32'hF8));
    wait_valid(ok);
    chk("wrap_instr_fc", bus.Instr_o, tag(BASE + 32'hFC));
    chk("wrap_pc_fc", bus.PC_o, BASE + 32'hFC);
    @(negedge clk);
    chk("wrap_pc_next", bus.PC_o, BASE);

    // ---- 10 handshakes with 2 squashes in HOLD (ready high together with jump)
    do_reset();
    bus.run_i = 1'b1;
    bus.Instr_ready_i = 1'b1;
    mpc = BASE;
    for (int i = 0; i < 12; i++) begin
      wait_valid(ok);
      if (!ok) break;
      chk($sformatf("sq%0d_instr", i), bus.Instr_o, tag(mpc));
      if (i == 3 || i == 7) begin
        bus.jump_en_i = 1'b1;
        bus.jump_addr_i = mpc;
        @(negedge clk);
        bus.jump_en_i = 1'b0;
        chk($sformatf("sq%0d_squash_valid", i), 32'(bus.Instr_valid_o), 32'h0);
      end else begin
        mpc = nxt(mpc);
      end
    end
    @(negedge clk);
    bus.Instr_ready_i = 1'b0;
    bus.run_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("sq_pc", bus.PC_o, mpc);
`ifdef FETCH_COUNT_EN
    chk("sq_count", fcount, 32'd10);
`endif

    // ---- asynchronous reset during CAPTURE
    do_reset();
    bus.run_i = 1'b1;
    bus.Instr_ready_i = 1'b1;
    wait_valid(ok);
    @(posedge clk);
    #1 bus.Instr_ready_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.PC_o, BASE);
    chk("arst_instr", bus.Instr_o, 32'h0);
    chk("arst_valid", 32'(bus.Instr_valid_o), 32'h0);
    chk("arst_busy", 32'(bus.Fetch_busy_o), 32'h0);
    bus.run_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("arst_idle%0d_busy", j), 32'(bus.Fetch_busy_o), 32'h0);
      chk($sformatf("arst_idle%0d_valid", j), 32'(bus.Instr_valid_o), 32'h0);
    end

    // ---- randomized run against a transaction-level model:
    // PC advances on each accepted handshake, jumps overwrite it, a valid word is mem[PC]
    do_reset();
    mpc = BASE;
    hs = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk("rnd_pc", bus.PC_o, mpc);
      chk("rnd_addr", bus.Mem_Address_o, mpc);
      if (bus.Instr_valid_o) begin
        chk("rnd_instr", bus.Instr_o, tag(mpc));
        chk("rnd_busy", 32'(bus.Fetch_busy_o), 32'h1);
      end
      vnow = bus.Instr_valid_o;
      jmp  = ($urandom_range(0, 11) == 0);
      bus.run_i         = ($urandom_range(0, 3) != 0);
      bus.Instr_ready_i = 1'($urandom_range(0, 1));
      bus.jump_en_i     = jmp;
      bus.jump_addr_i   = ($urandom_range(0, 1) == 1) ? BASE + 32'($urandom_range(0, 255)) : $urandom;
      if (jmp)
        mpc = {bus.jump_addr_i[31:2], 2'b00};
      else if (vnow && bus.Instr_ready_i) begin
        mpc = nxt(mpc);
        hs++;
      end
    end
    @(negedge clk);
    chk("rnd_final_pc", bus.PC_o, mpc);
    chk("rnd_progress", 32'(hs > 20), 32'h1);
`ifdef FETCH_COUNT_EN
    chk("rnd_count", fcount, 32'(hs));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
